// File: rtl/noc_sram_target.sv
// NoC target endpoint in front of a single-port SRAM bank.
// Decodes its address window, applies byte-strobed writes and answers every request with a 2-cycle ack.
module noc_sram_target #(
  parameter int unsigned           DATA_WIDTH  = 128,
  parameter int unsigned           ADDR_WIDTH  = 56,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 56'h0000_0000_1000_0000,
  parameter int unsigned           DEPTH_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [3:0]              qos,
  input  logic [7:0]              user,
  output logic                    ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error,
  output logic                    busy,
  output logic [31:0]             cnt_rd,
  output logic [31:0]             cnt_wr,
  output logic [31:0]             cnt_err
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH_WORDS * STRB_W);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  state_e state_q, state_d;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;
  logic [31:0]           cnt_rd_q, cnt_wr_q, cnt_err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH:0]   offset;
  logic                  in_win, aligned, fault;
  logic [IDX_W-1:0]      idx;
  logic                  unused_ok;

  // One extra bit on the subtraction so addresses below BASE_ADDR show up as negative
  assign offset  = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_win  = !offset[ADDR_WIDTH] && (offset[ADDR_WIDTH-1:0] < WIN_BYTES);
  assign aligned = (addr_q[OFF_W-1:0] == '0);
  assign fault   = !(in_win && aligned);
  assign idx     = offset[OFF_W +: IDX_W];

  assign unused_ok = ^{qos, user};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (state_q == ACCESS) begin
        error_q <= fault;
        if (fault) begin
          rdata_q   <= '0;
          cnt_err_q <= sat_inc(cnt_err_q);
        end else if (we_q) begin
          cnt_wr_q  <= sat_inc(cnt_wr_q);
        end else begin
          rdata_q   <= mem[idx];
          cnt_rd_q  <= sat_inc(cnt_rd_q);
        end
      end else if (state_q == RESP) begin
        error_q <= 1'b0;
      end
    end
  end

  // SRAM array is deliberately left out of reset; rst still blocks a write at the ACCESS edge
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q && !fault && !rst) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign ack     = (state_q == RESP);
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;
  assign error   = error_q;
  assign cnt_rd  = cnt_rd_q;
  assign cnt_wr  = cnt_wr_q;
  assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_noc_sram_target.sv
// Scoreboard bench for noc_sram_target: stimulus pushes expected responses, a monitor checks each ack.
module tb_noc_sram_target;

  localparam logic [55:0] BASE = 56'h0000_0000_1000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         req, we;
  logic [55:0]  addr;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic [3:0]   qos;
  logic [7:0]   user;
  logic         ack, error, busy;
  logic [127:0] rdata;
  logic [31:0]  cnt_rd, cnt_wr, cnt_err;

  noc_sram_target #(
    .DATA_WIDTH (128),
    .ADDR_WIDTH (56),
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(256)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .qos(qos), .user(user), .ack(ack), .rdata(rdata),
    .error(error), .busy(busy), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           ack_cyc;
    bit           err;
    bit           chk_rd;
    logic [127:0] rd;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int exp_rd = 0, exp_wr = 0, exp_er = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && ack) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ack", 128'(ack), 128'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_cycle", 128'(cyc), 128'(e.ack_cyc));
        chk("error", 128'(error), 128'(e.err));
        if (e.chk_rd) chk("rdata", rdata, e.rd);
      end
    end
  end

  task automatic chk_cnt();
    chk("cnt_rd", 128'(cnt_rd), 128'(exp_rd));
    chk("cnt_wr", 128'(cnt_wr), 128'(exp_wr));
    chk("cnt_err", 128'(cnt_err), 128'(exp_er));
  endtask

  // Called at a negedge; leaves req asserted and returns at the negedge of the ack cycle.
  task automatic txn(input logic w, input logic [55:0] a, input logic [127:0] d,
                     input logic [15:0] s, input bit e, input bit c,
                     input logic [127:0] r, input bit b2b, output int acc);
    exp_t x;
    int   n;
    we = w; addr = a; wdata = d; wstrb = s; req = 1'b1;
    qos = 4'(a[3:0]); user = 8'(d[7:0]);
    if (b2b) @(posedge clk);
    @(posedge clk);
    #1;
    acc = cyc;
    x.ack_cyc = acc + 1; x.err = e; x.chk_rd = c; x.rd = r;
    exp_q.push_back(x);
    if (e) exp_er++; else if (w) exp_wr++; else exp_rd++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 10);
    if (!ack) chk("ack_timeout", 128'(ack), 128'(1));
    chk_cnt();
  endtask

  task automatic rel();
    req = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [127:0] D1   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D0   = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] ONES = '1;
  localparam logic [127:0] PART = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF0000;
  localparam logic [127:0] DA   = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] DB   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D7   = 128'h77770000_77770000_77770000_77770000;
  localparam logic [127:0] D8   = 128'h88881111_88882222_88883333_88884444;

  initial begin
    int acc, acc2;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0; qos = '0; user = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_error", 128'(error), 128'(0));
    chk("rst_rdata", rdata, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk_cnt();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 128'(busy), 128'(0));
      chk("idle_ack", 128'(ack), 128'(0));
    end

    // Full-word write then read
    txn(1'b1, BASE + 56'h20, D1, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0, acc); rel();
    txn(1'b0, BASE + 56'h20, '0, 16'h0, 1'b0, 1'b1, D1, 1'b0, acc); rel();

    // Partial strobes on index 3
    txn(1'b1, BASE + 56'h30, ONES, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0, acc); rel();
    txn(1'b1, BASE + 56'h30, '0, 16'h0003, 1'b0, 1'b0, '0, 1'b0, acc); rel();
    txn(1'b0, BASE + 56'h30, '0, 16'h0, 1'b0, 1'b1, PART, 1'b0, acc); rel();
    txn(1'b1, BASE + 56'h30, '0, 16'h0000, 1'b0, 1'b0, '0, 1'b0, acc); rel();
    txn(1'b0, BASE + 56'h30, '0, 16'h0, 1'b0, 1'b1, PART, 1'b0, acc); rel();

    // Faults; index 0 is what the out-of-range/misaligned writes would alias onto
    txn(1'b1, BASE, D0, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0, acc); rel();
    txn(1'b1, BASE + 56'h1000, '0, 16'hFFFF, 1'b1, 1'b1, '0, 1'b0, acc); rel();
    txn(1'b1, BASE + 56'h4, '0, 16'hFFFF, 1'b1, 1'b1, '0, 1'b0, acc); rel();
    txn(1'b0, BASE - 56'h10, '0, 16'h0, 1'b1, 1'b1, '0, 1'b0, acc); rel();
    txn(1'b0, BASE, '0, 16'h0, 1'b0, 1'b1, D0, 1'b0, acc); rel();
    txn(1'b0, BASE + 56'h20, '0, 16'h0, 1'b0, 1'b1, D1, 1'b0, acc); rel();

    // req held high through RESP must not start a second transaction
    txn(1'b1, BASE + 56'h70, D7, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0, acc);
    @(negedge clk);
    chk("held_no_reaccept", 128'(busy), 128'(0));
    rel();
    txn(1'b0, BASE + 56'h70, '0, 16'h0, 1'b0, 1'b1, D7, 1'b0, acc); rel();

    // Back-to-back write then read of the same index
    txn(1'b1, BASE + 56'h80, D8, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0, acc);
    txn(1'b0, BASE + 56'h80, '0, 16'h0, 1'b0, 1'b1, D8, 1'b1, acc2);
    chk("b2b_spacing", 128'(acc2 - acc), 128'(3));
    rel();

    // Reset during ACCESS of a write to index 5
    txn(1'b1, BASE + 56'h50, DA, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0, acc); rel();
    we = 1'b1; addr = BASE + 56'h50; wdata = DB; wstrb = 16'hFFFF; req = 1'b1;
    @(posedge clk);
    #1;
    chk("access_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_ack", 128'(ack), 128'(0));
    exp_rd = 0; exp_wr = 0; exp_er = 0;
    chk_cnt();
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_ack", 128'(ack), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    txn(1'b0, BASE + 56'h50, '0, 16'h0, 1'b0, 1'b1, DA, 1'b0, acc); rel();

    repeat (3) @(negedge clk);
    chk("pending_expect", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/noc_sram_target.md
# noc_sram_target

NoC target endpoint that terminates the SoC request/response protocol (req/we/addr/wdata/wstrb/qos/user in; ack/rdata/error out) in front of a local single-port SRAM bank. It sits on a router output port as the responder side of the core/GPU initiators, for example as on-chip scratchpad or boot RAM. It decodes its address window, applies byte-strobed writes, returns read data with a fixed latency, and flags out-of-window or misaligned accesses.

## Interface
- DATA_WIDTH, 128, NoC data width in bits; wstrb is DATA_WIDTH/8 bits.
- ADDR_WIDTH, 56, physical address width.
- BASE_ADDR, 56'h0000_0000_1000_0000, window base; must be aligned to DATA_WIDTH/8 bytes.
- DEPTH_WORDS, 256, SRAM depth in DATA_WIDTH words; a power of two, at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request valid; the initiator holds it and all request fields stable until it sees ack.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
- qos  in  4  accepted and ignored.
- user  in  8  accepted and ignored.
- ack  out  1  one-cycle response pulse.
- rdata  out  DATA_WIDTH  read data; valid only while ack=1.
- error  out  1  access fault; valid only while ack=1.
- busy  out  1  high whenever the state is not IDLE.
- cnt_rd, cnt_wr, cnt_err  out  32 each  saturating transaction counters.

## Operation
- State machine: IDLE → ACCESS → RESP → IDLE.
- IDLE: if req=1 at a rising edge, capture we, addr, wdata and wstrb, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: decode the captured address.
  - In window: BASE_ADDR ≤ addr < BASE_ADDR + DEPTH_WORDS·DATA_WIDTH/8.
  - Aligned: addr[log2(DATA_WIDTH/8)-1:0] = 0.
  - Index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(DEPTH_WORDS) bits.
  - Good write: at the edge leaving ACCESS, update only the strobed bytes. wstrb=0 completes normally with no change.
  - Good read: at the same edge, register the SRAM word into rdata.
  - Fault (outside window or misaligned): no SRAM write; rdata is registered as 0 and error as 1.
- RESP: ack=1 for exactly one cycle, then unconditionally return to IDLE. A req that is still high during RESP belongs to the transaction being acknowledged and is never re-accepted.
- Counters update at the edge leaving ACCESS:
  - A good read increments cnt_rd.
  - A good write, including wstrb=0, increments cnt_wr.
  - A fault increments only cnt_err.
  - Each counter saturates at 32'hFFFF_FFFF.
- SRAM contents are not reset. Reading a word that was never written returns undefined data.

## Timing
- Reset values: ack=0, error=0, rdata=0, busy=0, all counters 0, state IDLE.
- Request accepted at edge T (req=1, state IDLE).
- busy=1 during cycles T+1 and T+2.
- ack=1 during cycle T+2 only.
- The initiator may drop req, or present a new request, from cycle T+3. The earliest next acceptance is the edge ending T+3.
- Fixed latency is 2 cycles from acceptance to ack. Peak throughput is one transaction per 3 cycles.
- Read-after-write to the same index on back-to-back transactions returns the new data.
- Reset asserted in any state: immediately force state IDLE, ack=0, error=0, busy=0, counters 0.
  - If reset hits during ACCESS, no SRAM write occurs.
  - After release, the first rising edge with req=1 starts a fresh transaction.
- rdata holds its last registered value outside ack cycles. Checkers must ignore it there.

## Test plan
- Reset then idle: outputs are all zero; req=0 for 10 cycles → ack is never asserted and busy=0.
- Full-word write then read (defaults):
  - Write addr=BASE_ADDR+0x20, wdata=128'h0123…CDEF, wstrb=16'hFFFF → ack exactly 2 cycles after acceptance, error=0, cnt_wr=1.
  - Read the same address → rdata=128'h0123…CDEF, cnt_rd=1.
- Partial strobe:
  - Write 128'hFF…FF with wstrb=16'hFFFF, then write 128'h0 with wstrb=16'h0003.
  - Read back → rdata=128'hFF…FF0000 (the low 2 bytes cleared).
  - A further write with wstrb=0 leaves that value unchanged.
- Faults:
  - addr=BASE_ADDR+DEPTH_WORDS·16 (one past the top) → ack with error=1, rdata=0, cnt_err=1.
  - addr=BASE_ADDR+0x4 → error=1.
  - Read of BASE_ADDR−16 → error=1.
  - No SRAM word changes on any of these.
- Held req and back-to-back:
  - Keep req high through RESP → exactly one ack per transaction.
  - Present a new request at T+3 → accepted at the edge ending T+3 → ack at T+5.
- Reset mid-ACCESS:
  - Assert rst during the ACCESS cycle of a write to index 5 (whose known prior value is A) → ack stays 0, busy=0 immediately.
  - After reset, a read of index 5 returns A; cnt_wr=0.
